// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
// Iterative multiply/divide unit that owns the MIPS HI/LO register pair.
// Executes MULT, MULTU, DIV, DIVU (multi-cycle, W iterations) and
// MTHI/MTLO (single edge, no handshake).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   Start      operation request, sampled only while Busy=0
//   Op         000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   A, B       operands (A = dividend / MTHI/MTLO source, B = divisor)
//   Busy       high while a mult/div is in flight
//   Done       one-cycle pulse when HI/LO hold a new mult/div result
//   DivByZero  high with Done when the divisor was zero
//   HI, LO     architectural HI/LO registers
module mips_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [2:0]            Op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivByZero,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // Control and architectural state (reset)
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  // Datapath working registers (no reset; only meaningful in CALC/FINISH)
  logic [W-1:0]    acc_hi_q, acc_hi_d;   // partial product high / running remainder
  logic [W-1:0]    acc_lo_q, acc_lo_d;   // multiplier bits / quotient bits
  logic [W-1:0]    opnd_q, opnd_d;       // |multiplicand| or |divisor|
  logic [W-1:0]    a_raw_q, a_raw_d;     // unmodified A, returned in HI on divide-by-zero
  logic            is_div_q, is_div_d;
  logic            neg_q, neg_d;         // negate product / quotient in FINISH
  logic            rem_neg_q, rem_neg_d; // negate remainder in FINISH
  logic            zero_q, zero_d;       // divisor was zero

  // Two's-complement magnitude, only when the operand is treated as signed
  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  // One shift-add step: W+1-bit sum keeps the carry, then the pair shifts right
  logic [W:0]      mul_sum;
  // One restoring-division step on the remainder shifted left by one
  logic [W:0]      div_sh;
  logic [W-1:0]    div_diff;
  logic            div_ok;
  logic [2*W-1:0]  mul_res;
  logic            sa, sb;

  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
  assign div_sh   = {acc_hi_q, acc_lo_q[W-1]};
  assign div_ok   = (div_sh >= {1'b0, opnd_q});
  assign div_diff = div_sh[W-1:0] - opnd_q;
  assign mul_res  = neg_2w({acc_hi_q, acc_lo_q}, neg_q);

  // Signs only matter for the signed ops (Op[0]==0)
  assign sa = ~Op[0] & A[W-1];
  assign sb = ~Op[0] & B[W-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    zero_d    = zero_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (!Op[2]) begin
            state_d   = S_CALC;
            cnt_d     = '0;
            is_div_d  = Op[1];
            a_raw_d   = A;
            zero_d    = (B == '0);
            neg_d     = sa ^ sb;
            acc_hi_d  = '0;
            if (Op[1]) begin
              acc_lo_d  = mag(A, ~Op[0]);
              opnd_d    = mag(B, ~Op[0]);
              rem_neg_d = sa;
            end else begin
              acc_lo_d  = mag(B, ~Op[0]);
              opnd_d    = mag(A, ~Op[0]);
              rem_neg_d = 1'b0;
            end
          end else if (Op[1:0] == 2'b00) begin
            hi_d = A;
          end else if (Op[1:0] == 2'b01) begin
            lo_d = A;
          end
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          acc_hi_d = div_ok ? div_diff : div_sh[W-1:0];
          acc_lo_d = {acc_lo_q[W-2:0], div_ok};
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[W-1:1]};
        end
        if (cnt_q == CW'(W-1)) begin
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (!is_div_q) begin
          {hi_d, lo_d} = mul_res;
        end else if (zero_q) begin
          dbz_d = 1'b1;
          hi_d  = a_raw_q;
          lo_d  = '1;
        end else begin
          lo_d = neg_w(acc_lo_q, neg_q);
          hi_d = neg_w(acc_hi_q, rem_neg_q);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_hi_q  <= acc_hi_d;
    acc_lo_q  <= acc_lo_d;
    opnd_q    <= opnd_d;
    a_raw_q   <= a_raw_d;
    is_div_q  <= is_div_d;
    neg_q     <= neg_d;
    rem_neg_q <= rem_neg_d;
    zero_q    <= zero_d;
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: a 32-bit and an 8-bit instance run side by side
// against a cycle-level reference (countdown + plain integer arithmetic).
module tb_mips_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start [2];
  logic [2:0]  op    [2];
  logic [31:0] a     [2];
  logic [31:0] b     [2];

  logic        busy0, done0, dbz0, busy1, done1, dbz1;
  logic [31:0] hi0, lo0;
  logic [7:0]  hi1, lo1;

  mips_muldiv_unit #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .reset(rst_n), .Start(start[0]), .Op(op[0]), .A(a[0]), .B(b[0]),
    .Busy(busy0), .Done(done0), .DivByZero(dbz0), .HI(hi0), .LO(lo0)
  );

  mips_muldiv_unit #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .reset(rst_n), .Start(start[1]), .Op(op[1]), .A(a[1][7:0]), .B(b[1][7:0]),
    .Busy(busy1), .Done(done1), .DivByZero(dbz1), .HI(hi1), .LO(lo1)
  );

  logic        busy_o [2];
  logic        done_o [2];
  logic        dbz_o  [2];
  logic [31:0] hi_o   [2];
  logic [31:0] lo_o   [2];
  assign busy_o[0] = busy0;
  assign busy_o[1] = busy1;
  assign done_o[0] = done0;
  assign done_o[1] = done1;
  assign dbz_o[0]  = dbz0;
  assign dbz_o[1]  = dbz1;
  assign hi_o[0]   = hi0;
  assign hi_o[1]   = {24'd0, hi1};
  assign lo_o[0]   = lo0;
  assign lo_o[1]   = {24'd0, lo1};

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;
  int WD [2] = '{32, 8};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wmask(input int w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  // Reference result of a mult/div op on a w-bit unit, in plain arithmetic
  function automatic void compute(input int w, input logic [2:0] o,
                                  input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dbz);
    logic [63:0] mask, ua, ub, up;
    longint sa, sb, sq, sr;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, av} & mask;
    ub = {32'd0, bv} & mask;
    sa = ua[w-1] ? longint'(ua | ~mask) : longint'(ua);
    sb = ub[w-1] ? longint'(ub | ~mask) : longint'(ub);
    hi = '0; lo = '0; dbz = 1'b0; up = '0;
    case (o)
      3'd0: begin up = 64'(sa * sb); hi = 32'((up >> w) & mask); lo = 32'(up & mask); end
      3'd1: begin up = ua * ub;      hi = 32'((up >> w) & mask); lo = 32'(up & mask); end
      3'd2, 3'd3: begin
        if (ub == 64'd0) begin
          hi = 32'(ua); lo = 32'(mask); dbz = 1'b1;
        end else if (o == 3'd2) begin
          sq = sa / sb; sr = sa % sb;
          lo = 32'(64'(sq) & mask); hi = 32'(64'(sr) & mask);
        end else begin
          lo = 32'((ua / ub) & mask); hi = 32'((ua % ub) & mask);
        end
      end
      default: ;
    endcase
  endfunction

  // Cycle-level reference: a busy countdown of W+1 edges, result applied at its end
  int          m_cnt  [2];
  logic [31:0] m_hi   [2], m_lo [2], r_hi [2], r_lo [2];
  logic        m_done [2], m_dbz [2], r_dbz [2];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_cnt[d] = 0; m_hi[d] = '0; m_lo[d] = '0; m_done[d] = 1'b0; m_dbz[d] = 1'b0;
      end else begin
        m_done[d] = 1'b0;
        m_dbz[d]  = 1'b0;
        if (m_cnt[d] > 0) begin
          m_cnt[d]--;
          if (m_cnt[d] == 0) begin
            m_hi[d] = r_hi[d]; m_lo[d] = r_lo[d];
            m_done[d] = 1'b1; m_dbz[d] = r_dbz[d];
          end
        end else if (start[d]) begin
          if (op[d] <= 3'd3) begin
            compute(WD[d], op[d], a[d], b[d], r_hi[d], r_lo[d], r_dbz[d]);
            m_cnt[d] = WD[d] + 1;
          end else if (op[d] == 3'd4) begin
            m_hi[d] = a[d] & wmask(WD[d]);
          end else if (op[d] == 3'd5) begin
            m_lo[d] = a[d] & wmask(WD[d]);
          end
        end
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("busy%0d", d), {31'd0, busy_o[d]}, {31'd0, (m_cnt[d] > 0)});
        check($sformatf("done%0d", d), {31'd0, done_o[d]}, {31'd0, m_done[d]});
        check($sformatf("dbz%0d", d),  {31'd0, dbz_o[d]},  {31'd0, m_dbz[d]});
        check($sformatf("hi%0d", d),   hi_o[d], m_hi[d]);
        check($sformatf("lo%0d", d),   lo_o[d], m_lo[d]);
      end
    end
  end

  // Caller is at a negedge; Start is sampled at the following posedge (edge 0)
  task automatic issue(input int d, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start[d] = 1'b1; op[d] = o; a[d] = av; b[d] = bv;
    @(negedge clk);
    start[d] = 1'b0; a[d] = $urandom; b[d] = $urandom;
  endtask

  // Returns at the negedge where Done is seen; n counts edges after edge 0
  task automatic wait_done(input int d, input int exp_n);
    int n;
    logic ok;
    ok = 1'b0;
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done_o[d]) begin ok = 1'b1; break; end
    end
    if (!ok) check("done_timeout", 32'd0, 32'd1);
    else     check("done_latency", 32'(n), 32'(exp_n));
  endtask

  task automatic run_op(input int d, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed);
    issue(d, o, av, bv);
    wait_done(d, WD[d] + 1);
    check("res_hi", hi_o[d], eh);
    check("res_lo", lo_o[d], el);
    check("res_dbz", {31'd0, dbz_o[d]}, {31'd0, ed});
  endtask

  function automatic logic [31:0] pick(input int w);
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return wmask(w);
      2: return 32'd1 << (w - 1);
      3: return 32'd1;
      default: return $urandom & wmask(w);
    endcase
  endfunction

  logic [31:0] th, tl, hi_before;
  logic        tz;
  logic [2:0]  ro;
  int          guard;

  initial begin
    for (int d = 0; d < 2; d++) begin start[d] = 1'b0; op[d] = 3'd0; a[d] = '0; b[d] = '0; end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi_o[0], 32'd0);
    check("rst_lo", lo_o[0], 32'd0);
    check("rst_busy", {31'd0, busy_o[0]}, 32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);

    // Hand-computed pins on the reference arithmetic
    compute(32, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, th, tl, tz);
    check("model_multu_hi", th, 32'hFFFFFFFE);
    check("model_multu_lo", tl, 32'h00000001);
    compute(32, 3'd0, 32'hFFFFFFFD, 32'd7, th, tl, tz);
    check("model_mult_lo", tl, 32'hFFFFFFEB);
    compute(32, 3'd2, 32'h80000000, 32'hFFFFFFFF, th, tl, tz);
    check("model_divmin_lo", tl, 32'h80000000);
    check("model_divmin_hi", th, 32'h0);
    compute(8, 3'd2, 32'h81, 32'h02, th, tl, tz);
    check("model_div8", {th[7:0], tl[7:0]}, 32'h0000FFC1);

    // 32-bit directed
    run_op(0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op(0, 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op(0, 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op(0, 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run_op(0, 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    run_op(0, 3'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    check("dbz_one_cycle", {31'd0, dbz_o[0]}, 32'd0);

    // MTHI while busy is ignored; new op accepted in the Done cycle
    issue(0, 3'd1, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    hi_before = hi_o[0];
    start[0] = 1'b1; op[0] = 3'd4; a[0] = 32'hDEAD;
    @(negedge clk);
    start[0] = 1'b0;
    check("mthi_ignored", hi_o[0], hi_before);
    wait_done(0, 27);
    check("mul67_lo", lo_o[0], 32'd42);
    issue(0, 3'd1, 32'd3, 32'd5);
    wait_done(0, 33);
    check("b2b_hi", hi_o[0], 32'd0);
    check("b2b_lo", lo_o[0], 32'd15);

    // MTHI while idle
    @(negedge clk);
    start[0] = 1'b1; op[0] = 3'd4; a[0] = 32'hCAFE;
    @(negedge clk);
    start[0] = 1'b0;
    check("mthi_hi", hi_o[0], 32'hCAFE);
    check("mthi_busy", {31'd0, busy_o[0]}, 32'd0);
    check("mthi_done", {31'd0, done_o[0]}, 32'd0);

    // Asynchronous reset in the middle of CALC
    issue(0, 3'd1, 32'd9, 32'd9);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi", hi_o[0], 32'd0);
    check("arst_lo", lo_o[0], 32'd0);
    check("arst_busy", {31'd0, busy_o[0]}, 32'd0);
    check("arst_done", {31'd0, done_o[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 3'd1, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0);

    // 8-bit directed
    run_op(1, 3'd0, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0);
    run_op(1, 3'd2, 32'h81, 32'h02, 32'hFF, 32'hC1, 1'b0);
    run_op(1, 3'd2, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0);

    // Randomized ops on both widths, checked every cycle by the reference
    for (int i = 0; i < 200; i++) begin
      ro = 3'($urandom_range(0, 7));
      for (int d = 0; d < 2; d++) begin
        start[d] = 1'b1; op[d] = ro; a[d] = pick(WD[d]); b[d] = pick(WD[d]);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        start[d] = 1'b0; a[d] = $urandom; b[d] = $urandom;
      end
      guard = 0;
      while ((busy_o[0] || busy_o[1]) && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 40) check("rand_busy_timeout", 32'd0, 32'd1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the MIPS core. It owns the HI/LO register pair and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- It sits beside the ALU. The core starts an operation with a Start pulse, stalls on Busy, and reads HI/LO (MFHI/MFLO) directly from the output ports.
- It generalises the single-cycle ALU with a multi-cycle mode, a width parameter and a start/busy/done handshake.

Parameters:
DATA_WIDTH, 32, operand width W and HI/LO register width; must be at least 4.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Start  input  1  operation request; sampled only when Busy=0
Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
A  input  W  operand A (rs); dividend for DIV/DIVU; source data for MTHI/MTLO
B  input  W  operand B (rt); divisor for DIV/DIVU
Busy  output  1  high while a mult/div operation is in progress
Done  output  1  one-cycle pulse when HI/LO hold a new mult/div result
DivByZero  output  1  high with Done when a DIV/DIVU had B==0
HI  output  W  HI register
LO  output  W  LO register

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; HI=0, LO=0, Done=0, DivByZero=0, Busy=0. Reset mid-operation aborts it with no partial HI/LO update.
- FSM states:
  - IDLE: on Start with Op mult/div, go to CALC.
  - CALC: runs W iterations, then goes to FINISH.
  - FINISH: sign correction and HI/LO write, then returns to IDLE.
- Busy = (state != IDLE), decoded combinationally from the state register.
- Start is ignored when Busy=1.
- Latency:
  - Start sampled at edge 0 moves the FSM to CALC.
  - Edges 1..W perform the iterations; the FSM enters FINISH at edge W.
  - Edge W+1 writes HI/LO, sets Done=1 and returns to IDLE.
  - Busy is high W+1 cycles. Done and the new HI/LO are visible together for one cycle after edge W+1.
- Done and DivByZero are registered and clear the following cycle.
- A Start in the Done cycle is accepted, allowing back-to-back operations.
- A and B are latched at the Start edge; later changes on A/B have no effect.
- Multiply: radix-2 shift-add on magnitudes with a 2W-bit product. {HI,LO} = product.
  - MULT: the product is negated in FINISH if the operand signs differ.
  - MULTU: plain unsigned product.
- Divide: restoring division on magnitudes, producing a W-bit quotient and remainder.
  - LO = quotient, HI = remainder.
  - DIV: quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
  - DIV of the most-negative value by -1: LO = most-negative value (wraps), HI = 0.
- Divide by zero (B==0): same latency. HI = original A, LO = all ones, DivByZero=1 with Done. Applies to both DIV and DIVU.
- MTHI/MTLO (Start with Busy=0): HI (or LO) = A at the sampling edge. No Busy, no Done; the FSM stays in IDLE.
- Op 11x with Start: no state change and no register change.
- HI/LO hold their value at all times except at the FINISH write, an MTHI/MTLO write, or reset.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high 33 cycles; Done pulse 33 cycles after the Start edge; HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU A=0x1234, B=0 -> HI=0x1234, LO=0xFFFFFFFF, DivByZero=1 for exactly one cycle.
- Handshake:
  - Pulse Start again mid-CALC with Op=MTHI -> ignored; HI is unchanged until FINISH.
  - Issue a new MULTU 3*5 in the Done cycle -> accepted; HI=0, LO=15 after a further 33 cycles.
  - MTHI A=0xCAFE while idle -> HI=0xCAFE after the next edge; Busy=0, Done=0.
- Reset: drive reset=0 at cycle 10 of CALC -> HI=LO=0, Busy=0, Done=0 immediately, without waiting for a clock edge. After release, MULTU 2*2 -> LO=4.
- DATA_WIDTH=8: MULT 0x80*0x80 -> HI=0x40, LO=0x00; DIV 0x81 (-127) / 0x02 -> LO=0xC1 (-63), HI=0xFF (-1); Done 9 cycles after the Start edge.
